mfhwt_ppbuf_writer: RTL
=======================

// Module: mfhwt_ppbuf_writer
// PURPOSE
//  Write-side controller for the 640x4 ping-pong line buffer.
//  - Takes a raster pixel stream (valid/ready) and drives the buffer's select, 8-bit wrreq and 16-bit data inputs.
//  - Each group of ROWS lines is routed into the 4 row FIFOs of the current write bank.
//  - Banks swap once the group is complete and the read bank has drained.
//  - Sits between the pixel source and the ping-pong buffer; the Haar-wavelet reader consumes the other bank.
// PARAMETERS
//  LINE_W  640  pixels per line; column counter wraps at LINE_W-1
//  ROWS    4    lines per bank, one FIFO per row; fixed to 4 to match the 8-bit wrreq
//  DATA_W  16   pixel width
// PORTS
//  iClk      in   1       clock
//  iRst      in   1       synchronous reset, active-high
//  iValid    in   1       upstream pixel valid
//  iData     in   DATA_W  upstream pixel
//  oReady    out  1       pixel accepted when iValid && oReady
//  iFull     in   8       buffer full flags {bank1[3:0],bank0[3:0]}
//  iEmpty    in   2       buffer empty flags {bank1,bank0}
//  oSelect   out  1       0: write bank0, read bank1; 1: write bank1, read bank0
//  oWrreq    out  8       one-hot write strobe, bit = 4*bank + row
//  oData     out  DATA_W  write data, aligned with oWrreq
//  oSwap     out  1       1-cycle pulse in the cycle oSelect toggles (new read bank ready)
//  oOverrun  out  1       sticky error: iValid held while blocked by iFull in FILL
// BEHAVIOUR
//  Reset (sync, any state, mid-line included):
//  - state=FILL, col=0, row=0.
//  - oSelect=0, oWrreq=0, oData=0, oSwap=0, oOverrun=0.
//  - Buffer contents are not cleared by this block.
//  Target bit: t = 4*oSelect + row.
//  oReady = (state==FILL) && !iFull[t]; combinational from state and iFull.
//  Accept in cycle N:
//  - At the edge ending N: oWrreq <= one-hot(t), oData <= iData.
//  - Latency is 1 cycle; no accept in N means oWrreq=0 in N+1.
//  Counters advance only on accept:
//  - col increments; at LINE_W-1 col wraps to 0 and row increments.
//  - At row ROWS-1 with col LINE_W-1, row wraps to 0 and state -> WAIT.
//  FSM:
//  - FILL: accept pixels as above.
//  - WAIT: oReady=0. Moves to FILL only when oWrreq==0 (last write retired) and iEmpty[~oSelect]==1 (read bank drained).
//    On that edge oSelect toggles, and oSwap=1 for the following cycle.
//  - Minimum WAIT dwell is 1 cycle, because the last write is still in flight.
//  oSelect is stable in any cycle where oWrreq != 0; the buffer gates and demuxes on it.
//  At power-up bank1 is empty, so the first swap happens 1 cycle after the last pixel of lines 0..3 is written.
//  Simultaneous events:
//  - If iEmpty rises in the same cycle the last write retires, the swap takes effect at that edge.
//  - iFull is ignored in WAIT.
//  oOverrun sets when state==FILL && iValid && iFull[t]; it is cleared only by reset.
// TESTING
//  T1 reset: pulse iRst mid-stream -> next cycle oSelect=0, oWrreq=0, oData=0, oReady=1, oOverrun=0.
//  T2 first fill, iValid=1, iEmpty=2'b11, iFull=0:
//     - 2560 accepts -> oWrreq=8'h01 for cycles 1..640, 8'h02 for 641..1280, 8'h04 next, 8'h08 for 1921..2560.
//     - oData equals the input delayed 1 cycle.
//     - oSelect=1 and oSwap=1 at cycle 2562.
//  T3 backpressure: bank1 full of data with iEmpty[1]=0 after bank0 completes.
//     - oReady=0 and oSelect holds at 0 indefinitely.
//     - Raise iEmpty[1] -> toggle at that edge; oSwap pulses once; next accepts strobe 8'h10.
//  T4 gaps: random iValid idle cycles during a line -> col/row hold; total oWrreq pulses per FIFO still 640.
//  T5 full: iFull[2]=1 while row=2 -> oReady=0, no strobe, oOverrun=1.
//     - Drop iFull[2] -> writes resume at the same col; oOverrun stays 1.
//  T6 ping-pong: 3 full groups -> oSelect sequence 0,1,0,1; strobes alternate between 8'h0X and 8'hX0 ranges.

Source files
------------

// File: rtl/mfhwt_ppbuf_writer.sv
// Write-side controller for the ping-pong line buffer: routes a raster pixel
// stream into the 4 row FIFOs of the write bank and swaps banks per group.
module mfhwt_ppbuf_writer #(
    parameter int LINE_W = 640,
    parameter int ROWS   = 4,
    parameter int DATA_W = 16
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iValid,
    input  logic [DATA_W-1:0] iData,
    output logic              oReady,
    input  logic [7:0]        iFull,
    input  logic [1:0]        iEmpty,
    output logic              oSelect,
    output logic [7:0]        oWrreq,
    output logic [DATA_W-1:0] oData,
    output logic              oSwap,
    output logic              oOverrun
);

    localparam int COL_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W - 1);
    localparam logic [1:0]       ROW_LAST = 2'(ROWS - 1);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]        state_r;
    logic [COL_W-1:0]  col_r;
    logic [1:0]        row_r;
    logic              select_r;
    logic [7:0]        wrreq_r;
    logic [DATA_W-1:0] data_r;
    logic              swap_r;
    logic              overrun_r;

    logic [2:0] tgt_s;
    logic       full_tgt_s;
    logic       ready_s;
    logic       accept_s;
    logic       read_empty_s;
    logic       swap_go_s;

    // Target FIFO, handshake and swap qualification
    always_comb begin
        tgt_s        = {select_r, row_r};
        full_tgt_s   = iFull[tgt_s];
        ready_s      = (state_r == ST_FILL) && !full_tgt_s;
        accept_s     = ready_s && iValid;
        read_empty_s = select_r ? iEmpty[0] : iEmpty[1];
        // The last strobe must have retired so oSelect never moves under a write
        swap_go_s    = (state_r == ST_WAIT) && (wrreq_r == 8'h00) && read_empty_s;
    end

    // FSM, raster counters and bank select
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_r  <= ST_FILL;
            col_r    <= '0;
            row_r    <= 2'd0;
            select_r <= 1'b0;
        end else begin
            case (state_r)
                ST_FILL: begin
                    if (accept_s) begin
                        if (col_r == COL_LAST) begin
                            col_r <= '0;
                            if (row_r == ROW_LAST) begin
                                row_r   <= 2'd0;
                                state_r <= ST_WAIT;
                            end else begin
                                row_r <= row_r + 2'd1;
                            end
                        end else begin
                            col_r <= col_r + COL_W'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (swap_go_s) begin
                        state_r  <= ST_FILL;
                        select_r <= ~select_r;
                    end
                end
                default: begin
                    state_r <= ST_FILL;
                end
            endcase
        end
    end

    // Write strobe and data pipeline stage
    always_ff @(posedge iClk) begin
        if (iRst) begin
            wrreq_r <= 8'h00;
            data_r  <= '0;
        end else if (accept_s) begin
            wrreq_r <= 8'h01 << tgt_s;
            data_r  <= iData;
        end else begin
            wrreq_r <= 8'h00;
        end
    end

    // Swap pulse and sticky overrun flag
    always_ff @(posedge iClk) begin
        if (iRst) begin
            swap_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            swap_r <= swap_go_s;
            if ((state_r == ST_FILL) && iValid && full_tgt_s) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign oReady   = ready_s;
    assign oSelect  = select_r;
    assign oWrreq   = wrreq_r;
    assign oData    = data_r;
    assign oSwap    = swap_r;
    assign oOverrun = overrun_r;

endmodule
